// File: rtl/serial_debug_master_pkg.sv
// Shared command codes and FSM state encoding for the serial debug initiator.
package serial_debug_master_pkg;

    localparam logic [7:0] CMD_INC   = 8'h00;
    localparam logic [7:0] CMD_LEDS  = 8'h01;
    localparam logic [7:0] CMD_COUNT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/serial_debug_master_dbg_timeout_timer.sv
// Reply-deadline counter: cleared on the transmit strobe, counts while enabled and
// parks at TIMEOUT-1 so expiry stays asserted until the next clear.
module dbg_timeout_timer #(
    parameter int TIMEOUT = 4200,
    parameter int TW      = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/serial_debug_master.sv
// Initiator for the single-byte debug protocol: sends one command byte, then returns
// the first byte received afterwards or a timeout if the deadline passes.
module serial_debug_master
    import serial_debug_master_pkg::*;
#(
    parameter int TIMEOUT = 4200,
    parameter int TW      = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    input  logic [7:0] req_cmd,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [7:0] err_count,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_rcv,
    input  logic [7:0] rx_data,
    output logic [1:0] dbg_state
);

    // Handshake: a request is taken on any cycle where req_valid && req_ready; req_ready
    // is high exactly while the FSM sits in IDLE, so a request raised while busy simply
    // waits. rsp_valid is a single-cycle pulse; rsp_data/rsp_timeout hold until the next.

    state_e     state_q, state_d;
    logic       req_ready_q, busy_q;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_timeout_q, rsp_timeout_d;
    logic [7:0] err_count_q, err_count_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       timer_clr, timer_en, timer_expired;
    logic       accept;

    assign accept = req_valid && req_ready_q;

    dbg_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)                    state_d = ST_SEND;
            ST_SEND: if (tx_ready)                  state_d = ST_WAIT;
            ST_WAIT: if (rx_rcv || timer_expired)   state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        err_count_d   = err_count_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) tx_data_d = req_cmd;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                timer_en = 1'b1;
                // A reply landing on the expiry cycle still counts as a reply.
                if (rx_rcv) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = rx_data;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    rsp_valid_d   = 1'b1;
                    rsp_data_d    = 8'h00;
                    rsp_timeout_d = 1'b1;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= 8'h00;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
        end else begin
            req_ready_q   <= (state_d == ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_count_q   <= err_count_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_count   = err_count_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_debug_master.sv
// Bench for serial_debug_master: behavioural transmitter/receiver/responder stand-in
// plus an expected-reply queue checked whenever rsp_valid pulses.
module tb_serial_debug_master;
    import serial_debug_master_pkg::*;

    localparam int TIMEOUT = 20;
    localparam int RSP_DLY = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_cmd = 8'h00;
    logic       req_ready, rsp_valid, rsp_timeout, busy, tx_start;
    logic [7:0] rsp_data, err_count, tx_data;
    logic       tx_ready = 1'b1;
    logic       rx_rcv = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] dbg_state;

    serial_debug_master #(.TIMEOUT(TIMEOUT), .TW(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy), .err_count(err_count),
        .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_rcv(rx_rcv), .rx_data(rx_data), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- test-owned knobs
    int         resp_dly = RSP_DLY;   // 0 = responder silent
    logic       tx_hold = 1'b0;
    int         stray_seq = 0;
    logic [3:0] leds = 4'h5;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    // ---------------- model-owned state
    int         rdly_cnt = 0, txb_cnt = 0, stray_done = 0;
    int         tx_start_cnt = 0, tx_start_cyc = 0;
    logic [7:0] pend = 8'h00, last_tx = 8'h00, remote_cnt = 8'h00;

    // uart_tx/uart_rx stand-ins and remote responder, all stepping on the falling edge
    always @(negedge clk) begin
        rx_rcv = 1'b0;
        if (!rstn) begin
            rdly_cnt = 0;
            txb_cnt  = 0;
            tx_ready = 1'b1;
        end else begin
            if (rdly_cnt > 0) begin
                rdly_cnt--;
                if (rdly_cnt == 0) begin
                    rx_rcv  = 1'b1;
                    rx_data = pend;
                end
            end
            if (stray_done != stray_seq) begin
                stray_done = stray_seq;
                rx_rcv     = 1'b1;
                rx_data    = 8'h77;
            end
            if (txb_cnt > 0) txb_cnt--;
            if (tx_start) begin
                tx_start_cnt++;
                tx_start_cyc = cyc;
                last_tx      = tx_data;
                txb_cnt      = 4;
                if (resp_dly > 0) begin
                    rdly_cnt = resp_dly;
                    if (ovr_en) begin
                        pend = ovr_val;
                    end else begin
                        case (tx_data)
                            CMD_INC:   begin remote_cnt = remote_cnt + 8'd1; pend = 8'h00; end
                            CMD_LEDS:  pend = {4'h0, leds};
                            CMD_COUNT: pend = remote_cnt;
                            default:   pend = 8'h00;
                        endcase
                    end
                end
            end
            tx_ready = !tx_hold && (txb_cnt == 0);
        end
    end

    // ---------------- scoreboard and checking
    logic [8:0] exp_q[$];
    int         n_vec = 0, n_err = 0;
    int         tx_cnt_at_req = 0;
    logic [7:0] last_cmd = 8'h00;
    int         exp_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call on a falling edge; returns on the falling edge after acceptance.
    task automatic send_req(input logic [7:0] cmd, input logic exp_to, input logic [7:0] exp_data);
        int n = 0;
        exp_q.push_back({exp_to, exp_data});
        tx_cnt_at_req = tx_start_cnt;
        last_cmd      = cmd;
        req_valid     = 1'b1;
        req_cmd       = cmd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        int n = 0;
        int viol = 0;
        logic [8:0] exp;
        logic [7:0] held;
        while (!rsp_valid && n < 2000) begin
            if (req_ready || !busy) viol++;
            @(negedge clk);
            n++;
        end
        rsp_cyc = cyc;
        check_eq("rsp_seen", rsp_valid, 1);
        check_eq("busy_ready_in_txn", viol, 0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        check_eq("rsp_timeout", rsp_timeout, exp[8]);
        check_eq("rsp_data", rsp_data, exp[7:0]);
        check_eq("tx_start_count", tx_start_cnt - tx_cnt_at_req, 1);
        check_eq("tx_data_sent", last_tx, last_cmd);
        held = rsp_data;
        @(negedge clk);
        check_eq("rsp_valid_pulse", rsp_valid, 0);
        check_eq("rsp_data_held", rsp_data, held);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        int spur;
        int hold_cnt;
        int rel_cyc;

        // reset state
        #12;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_timeout", rsp_timeout, 0);
        check_eq("rst_tx_start", tx_start, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);

        // 1: LEDS read
        send_req(CMD_LEDS, 1'b0, 8'h05);
        wait_rsp(rc);
        check_eq("t1_latency", rc - tx_start_cyc, RSP_DLY + 1);

        // 3: three INC then COUNT
        for (int i = 0; i < 3; i++) begin
            send_req(CMD_INC, 1'b0, 8'h00);
            wait_rsp(rc);
        end
        send_req(CMD_COUNT, 1'b0, 8'h03);
        wait_rsp(rc);

        // 2: silent responder -> timeout
        resp_dly = 0;
        send_req(CMD_LEDS, 1'b1, 8'h00);
        wait_rsp(rc);
        exp_err++;
        check_eq("t2_timeout_latency", rc - tx_start_cyc, TIMEOUT);
        check_eq("t2_err_count", err_count, exp_err);

        // 4: transmitter busy for 50 cycles after accept
        resp_dly = RSP_DLY;
        tx_hold  = 1'b1;
        repeat (2) @(negedge clk);
        send_req(CMD_COUNT, 1'b0, 8'h03);
        hold_cnt = tx_start_cnt;
        repeat (50) @(negedge clk);
        check_eq("t4_no_strobe", tx_start_cnt, hold_cnt);
        check_eq("t4_state_send", dbg_state, ST_SEND);
        check_eq("t4_tx_data", tx_data, CMD_COUNT);
        rel_cyc = cyc;
        tx_hold = 1'b0;
        wait_rsp(rc);
        check_eq("t4_start_after_ready", tx_start_cyc > rel_cyc, 1);
        check_eq("t4_latency", rc - tx_start_cyc, RSP_DLY + 1);

        // 5a: reply lands on the expiry cycle
        resp_dly = TIMEOUT - 1;
        ovr_en   = 1'b1;
        ovr_val  = 8'hA5;
        send_req(8'h33, 1'b0, 8'hA5);
        wait_rsp(rc);
        check_eq("t5_edge_latency", rc - tx_start_cyc, TIMEOUT);
        check_eq("t5_edge_err", err_count, exp_err);
        ovr_en = 1'b0;

        // 5b: saturate err_count
        resp_dly = 0;
        for (int i = 0; i < 259; i++) begin
            send_req(8'h10, 1'b1, 8'h00);
            wait_rsp(rc);
            if (exp_err < 255) exp_err++;
            check_eq("t5_err_count", err_count, exp_err);
        end
        check_eq("t5_err_sat", err_count, 8'hFF);

        // 6: reset in WAIT, stray byte in IDLE, then normal transaction
        send_req(CMD_LEDS, 1'b0, 8'h00);
        repeat (8) @(negedge clk);
        check_eq("t6_in_wait", dbg_state, ST_WAIT);
        rstn = 1'b0;
        #1;
        check_eq("t6_rst_rsp_valid", rsp_valid, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_err", err_count, 0);
        check_eq("t6_rst_tx_data", tx_data, 0);
        check_eq("t6_rst_tx_start", tx_start, 0);
        check_eq("t6_rst_rsp_data", rsp_data, 0);
        check_eq("t6_rst_rsp_timeout", rsp_timeout, 0);
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        rstn = 1'b1;
        spur = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) spur++;
        end
        stray_seq++;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || busy) spur++;
        end
        check_eq("t6_no_spurious", spur, 0);
        resp_dly = RSP_DLY;
        send_req(CMD_LEDS, 1'b0, {4'h0, leds});
        wait_rsp(rc);
        check_eq("t6_err_after", err_count, exp_err);
        check_eq("t6_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
